// File: rtl/rca_pkg.sv
// Shared types and sizes for the four-requester shared-adder arbiter.
package rca_pkg;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int ID_W    = 2;

   typedef logic [ID_W-1:0]   req_id_t;
   typedef logic [DATA_W-1:0] word_t;

   function automatic req_id_t next_id(input req_id_t id);
      return id + req_id_t'(1);
   endfunction
endpackage

// File: rtl/rca.sv
// 32-bit ripple-carry adder, carry-in tied to 0, no internal pipelining.
module rca
   import rca_pkg::*;
(
   input  word_t a,
   input  word_t b,
   output word_t sum,
   output logic  cout
);

   logic c;

   always_comb begin
      c   = 1'b0;
      sum = '0;
      for (int i = 0; i < DATA_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/rr_arb4.sv
// Combinational round-robin grant: first set request at or above ptr, wrapping 3->0.
module rr_arb4
   import rca_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_id_t            ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output req_id_t            idx,
   output logic               any
);

   req_id_t cand;

   always_comb begin
      gnt  = '0;
      idx  = ptr;
      any  = 1'b0;
      cand = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ptr + req_id_t'(k);
         if (en && !any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/rca_arbiter.sv
// Four requesters share one ripple-carry adder; results land in a single-entry
// output register drained by a valid/ready consumer.
module rca_arbiter
   import rca_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output word_t                     res_sum,
   output logic                      res_cout,
   output req_id_t                   res_id,
   output logic [15:0]               ops_count
);

   logic    can_issue;
   logic    arb_en;
   logic    grant;
   req_id_t gnt_idx;
   req_id_t rr_ptr;
   word_t   a_sel;
   word_t   b_sel;
   word_t   sum;
   logic    cout;

   // A full register may only accept new data in the cycle it is drained.
   assign can_issue = !res_valid || res_ready;
   // Keep req_ready low for the whole time reset is held.
   assign arb_en    = can_issue && rst_n;

   rr_arb4 u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .en  (arb_en),
      .gnt (req_ready),
      .idx (gnt_idx),
      .any (grant)
   );

   assign a_sel = req_a[gnt_idx*DATA_W +: DATA_W];
   assign b_sel = req_b[gnt_idx*DATA_W +: DATA_W];

   rca u_rca (
      .a    (a_sel),
      .b    (b_sel),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_id    <= '0;
         rr_ptr    <= '0;
         ops_count <= '0;
      end else begin
         if (grant) begin
            res_valid <= 1'b1;
            res_sum   <= sum;
            res_cout  <= cout;
            res_id    <= gnt_idx;
            rr_ptr    <= next_id(gnt_idx);
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
         if (res_valid && res_ready) ops_count <= ops_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_rca_arbiter.sv
// Directed bench for rca_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_rca_arbiter;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  res_sum;
   logic         res_cout;
   logic [1:0]   res_id;
   logic [15:0]  ops_count;

   int n_cmp = 0;
   int n_err = 0;

   rca_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .ops_count (ops_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ready;
      logic        vld;
      logic        chk_data;
      logic [31:0] sum;
      logic        cout;
      logic [1:0]  id;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Valid requesters get the vector operands; idle ones carry distinct junk.
   task automatic drive_single(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b);
      req_valid = v;
      for (int i = 0; i < 4; i++) begin
         req_a[i*32 +: 32] = v[i] ? a : (32'hDEAD_BEE0 | 32'(i));
         req_b[i*32 +: 32] = v[i] ? b : (32'h0BAD_F000 | 32'(i));
      end
   endtask

   function automatic logic [31:0] op_a(input int i);
      return 32'h1000_0000 * 32'(i) + 32'h0000_0001;
   endfunction

   function automatic logic [31:0] op_b(input int i);
      return 32'(i) * 32'h0000_0101;
   endfunction

   task automatic drive_all(input logic [3:0] v);
      req_valid = v;
      for (int i = 0; i < 4; i++) begin
         req_a[i*32 +: 32] = op_a(i);
         req_b[i*32 +: 32] = op_b(i);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [15:0] exp_cnt;
   logic        m_valid;
   int          id_e;

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      res_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;

      vecs[0] = '{4'b0100, 32'h0000_0005, 32'h0000_0007, 4'b0100, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 2'd2, 16'd0};
      vecs[1] = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 2'd0, 16'd1};
      vecs[2] = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd0, 16'd2};
      vecs[3] = '{4'b1000, 32'h8000_0000, 32'h8000_0000, 4'b1000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 2'd3, 16'd2};
      vecs[4] = '{4'b0010, 32'h1234_5678, 32'h1111_1111, 4'b0010, 1'b1, 1'b1, 32'h2345_6789, 1'b0, 2'd1, 16'd3};
      vecs[5] = '{4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 2'd0, 16'd4};
      vecs[6] = '{4'b1000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b1000, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 2'd3, 16'd5};
      vecs[7] = '{4'b0100, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 2'd2, 16'd6};

      // Reset state, with requests pending to show req_ready is gated.
      req_valid = 4'b1111;
      #7;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_sum",   res_sum,        32'd0);
      chk("rst_res_cout",  32'(res_cout),  32'd0);
      chk("rst_res_id",    32'(res_id),    32'd0);
      chk("rst_ops_count", 32'(ops_count), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      do_reset();

      // Vector table, consumer always ready.
      res_ready = 1'b1;
      for (int v = 0; v < 8; v++) begin
         drive_single(vecs[v].valid, vecs[v].a, vecs[v].b);
         #1;
         chk($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(vecs[v].ready));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_res_valid", v), 32'(res_valid), 32'(vecs[v].vld));
         chk($sformatf("vec%0d_ops_count", v), 32'(ops_count), 32'(vecs[v].cnt));
         if (vecs[v].chk_data) begin
            chk($sformatf("vec%0d_res_sum", v),  res_sum,        vecs[v].sum);
            chk($sformatf("vec%0d_res_cout", v), 32'(res_cout),  32'(vecs[v].cout));
            chk($sformatf("vec%0d_res_id", v),   32'(res_id),    32'(vecs[v].id));
         end
         @(negedge clk);
      end

      // Round robin from reset with all four requesters valid.
      do_reset();
      res_ready = 1'b1;
      drive_all(4'b1111);
      exp_cnt = 16'd0;
      m_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         if (m_valid) exp_cnt = exp_cnt + 16'd1;
         m_valid = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("rr%0d_res_id", k),    32'(res_id),    32'(k % 4));
         chk($sformatf("rr%0d_res_sum", k),   res_sum,        op_a(k % 4) + op_b(k % 4));
         chk($sformatf("rr%0d_res_valid", k), 32'(res_valid), 32'd1);
         chk($sformatf("rr%0d_ops_count", k), 32'(ops_count), 32'(exp_cnt));
         @(negedge clk);
      end

      // Backpressure: result from requester 1 must hold for 5 cycles.
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_res_valid", k), 32'(res_valid), 32'd1);
         chk($sformatf("bp%0d_res_id", k),    32'(res_id),    32'd1);
         chk($sformatf("bp%0d_res_sum", k),   res_sum,        op_a(1) + op_b(1));
         chk($sformatf("bp%0d_ops_count", k), 32'(ops_count), 32'(exp_cnt));
         @(negedge clk);
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_req_ready", 32'(req_ready), 32'(4'b0100));
      exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
      chk("bp_release_res_valid", 32'(res_valid), 32'd1);
      chk("bp_release_res_id",    32'(res_id),    32'd2);
      chk("bp_release_res_sum",   res_sum,        op_a(2) + op_b(2));
      chk("bp_release_ops_count", 32'(ops_count), 32'(exp_cnt));
      @(negedge clk);

      // Reset mid-operation: requesters 1..3 leave rr_ptr at 2 with ops_count 3.
      do_reset();
      res_ready = 1'b1;
      drive_all(4'b1110);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         id_e = (k % 3) + 1;
         chk($sformatf("mid%0d_res_id", k), 32'(res_id), 32'(id_e));
      end
      @(negedge clk);
      chk("mid_pre_ops_count", 32'(ops_count), 32'd3);
      chk("mid_pre_res_valid", 32'(res_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      drive_all(4'b1111);
      #1;
      chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_ops_count", 32'(ops_count), 32'd0);
      chk("mid_rst_res_sum",   res_sum,        32'd0);
      chk("mid_rst_res_cout",  32'(res_cout),  32'd0);
      chk("mid_rst_res_id",    32'(res_id),    32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_post_req_ready", 32'(req_ready), 32'(4'b0001));
      @(posedge clk);
      #1;
      chk("mid_post_res_id",    32'(res_id),    32'd0);
      chk("mid_post_ops_count", 32'(ops_count), 32'd0);
      @(negedge clk);

      // Counter wrap: first edge only fills, each later edge is a handshake.
      do_reset();
      res_ready = 1'b1;
      drive_all(4'b0001);
      repeat (65536) @(posedge clk);
      #1;
      chk("wrap_ops_count_ffff", 32'(ops_count), 32'h0000_FFFF);
      @(posedge clk);
      #1;
      chk("wrap_ops_count_0000", 32'(ops_count), 32'h0000_0000);
      chk("wrap_res_valid",      32'(res_valid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rca_arbiter.md
# rca_arbiter

Shares one 32-bit ripple-carry adder (`RCA`) between four independent requesters. Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the sum, carry-out and requester ID are captured in a single-entry output register drained by a valid/ready consumer. The block sits between the datapath clients and the shared `RCA` instance, so no client ever drives the adder directly.

## Interface
- `NUM_REQ`, 4: number of requesters; fixed at 4 for this revision (ID is 2 bits).
- `DATA_W`, 32: operand width; fixed to the `RCA` width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 4: bit i set = requester i presents an operand pair.
- `req_ready` out 4: bit i set = requester i's pair is accepted this cycle.
- `req_a` in 128: operand A; requester i in bits [32i+31:32i].
- `req_b` in 128: operand B; same packing as `req_a`.
- `res_valid` out 1: result register holds a result.
- `res_ready` in 1: consumer accepts the result this cycle.
- `res_sum` out 32: registered `RCA` sum.
- `res_cout` out 1: registered `RCA` carry-out.
- `res_id` out 2: index of the requester that produced the result.
- `ops_count` out 16: number of completed results; wraps at 16 bits.

## Operation
- Grant enable: `can_issue = !res_valid || res_ready`.
- When `can_issue` is set, the arbiter picks the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping 3→0.
- `req_ready` is one-hot on the granted index, and all-zero when `can_issue` is low or no request is pending.
- `req_ready` is a combinational function of `req_valid`, `rr_ptr`, `res_valid` and `res_ready`; it never depends on `req_a` or `req_b`.
- Transfer on requester i = `req_valid[i] && req_ready[i]`. On transfer, the mux routes `req_a[i]` and `req_b[i]` to the `RCA`.
- At the same edge, the output register loads sum, cout and id = i, and `res_valid` is set.
- After a transfer to i, `rr_ptr` becomes (i+1) mod 4. Without a transfer, `rr_ptr` is unchanged.
- Output handshake:
  - If `res_valid && res_ready` and there is no new grant, `res_valid` clears.
  - If both happen in the same cycle, the register reloads and `res_valid` stays 1.
- `ops_count` increments by 1 on every output handshake (`res_valid && res_ready`). It wraps 0xFFFF→0x0000.
- Arithmetic: unsigned 32-bit add with carry-in 0 (as fixed in `RCA`). Overflow is reported only through `res_cout`; no saturation.
- Output states:
  - EMPTY (`res_valid=0`), on grant → FULL.
  - FULL, on `res_ready` with no grant → EMPTY.
  - FULL, on `res_ready` with a grant → stays FULL with new data.
  - FULL, without `res_ready` → holds.
- While FULL and `res_ready=0`, `res_sum`, `res_cout` and `res_id` are held stable and all `req_ready` bits are 0.
- Reset (async assert, any time including mid-transfer):
  - `res_valid=0`, `res_sum=0`, `res_cout=0`, `res_id=0`.
  - `rr_ptr=0`, `ops_count=0`.
  - `req_ready=0` while `rst_n` is low.
  - A pending result is discarded and not counted.

## Timing
- Latency: request transfer at edge t → `res_valid` high after edge t, so the result is visible in cycle t+1.
- Throughput: one result per cycle while `res_ready` stays high.
- Fairness: a continuously valid requester is granted within 4 grants.
- Critical path: `req_a`/`req_b` mux → 32-bit ripple chain → output register. No pipelining inside `RCA`.
- Requesters must hold `req_valid` and operands stable until their transfer; no requester may withdraw a pending request.

## Structure
- Shared package `rca_pkg`: `NUM_REQ=4`, `DATA_W=32`, `ID_W=2`, typedef `req_id_t` (2-bit), typedef `word_t` (32-bit).
- Sub-module `rr_arb4`: combinational round-robin grant.
  - Inputs: request vector, `rr_ptr`, enable.
  - Outputs: one-hot grant, encoded index, any-grant.
- Top level instantiates `rr_arb4` and one `RCA`, and holds the operand mux, output register, pointer and counter.

## Test plan
- Single request: only requester 2 is valid, a=0x0000_0005, b=0x0000_0007, `res_ready=1` → `req_ready=4'b0100` for one cycle; next cycle `res_valid=1`, `res_sum=0x0000_000C`, `res_cout=0`, `res_id=2`, `ops_count` goes 0→1.
- Overflow: a=0xFFFF_FFFF, b=0x0000_0001 → `res_sum=0x0000_0000`, `res_cout=1`.
- Round-robin: all four requesters valid continuously, `res_ready=1`, from reset → `res_id` sequence 0,1,2,3,0,1; one result per cycle.
- Backpressure: `res_ready=0` for 5 cycles with requesters pending → `res_valid` held at 1, outputs stable, `req_ready=0`, `ops_count` unchanged; on `res_ready=1`, drain and refill occur in the same cycle.
- Reset mid-operation: assert `rst_n=0` asynchronously while `res_valid=1` and `ops_count=3` → `res_valid`, `ops_count`, `rr_ptr` and data outputs all read 0 immediately; after release, the first grant goes to the lowest valid index starting from 0.
- Counter wrap: preload by running 65536 handshakes → `ops_count` reads 0x0000.
